ff_array_param: RTL and testbench
=================================

# ff_array_param

Parametrised flip-flop register array with per-entry valid tracking, byte-enable writes, bulk clear and a registered read port. It stores up to DEPTH words of WIDTH bits in the control/status path and flags illegal accesses. It generalises the fixed 8x8 flip-flop array: width and depth are configurable, and it adds byte masking, an out-of-range check, clear, a hit flag and an occupancy count.

## Interface
- WIDTH, 8, data width in bits; must be a multiple of 8, minimum 8
- DEPTH, 8, number of entries; minimum 2, need not be a power of two
- AW (derived), $clog2(DEPTH), address width
- BW (derived), WIDTH/8, byte-enable width
- CW (derived), $clog2(DEPTH+1), occupancy counter width

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- din  in  WIDTH  write data
- addr  in  AW  entry address for read or write
- wr  in  1  write request
- rd  in  1  read request
- be  in  BW  byte enables for the write; be[i] covers din[8i+7:8i]
- clr  in  1  invalidate and zero all entries
- dout  out  WIDTH  registered read data
- dout_valid  out  1  read response strobe
- hit  out  1  addressed entry was valid at read time
- error  out  1  illegal-access strobe
- valid_cnt  out  CW  number of currently valid entries

## Operation
Inputs are sampled at each rising clk. The first matching case below applies:
- **clr=1:** all entries zeroed and all valid bits cleared; valid_cnt becomes 0.
  - wr, rd and addr are ignored.
  - No error and no read response.
- **wr=1 and rd=1:** illegal access.
  - error pulses.
  - No state change and no read response.
- **addr >= DEPTH with wr or rd:** out-of-range access.
  - error pulses.
  - No state change and no read response.
- **Write (wr=1, rd=0):**
  - For each i with be[i]=1, byte i of the entry takes din byte i.
  - Bytes with be[i]=0 keep their old value. If the entry was invalid, those bytes become 0.
  - The valid bit is set when be is non-zero.
  - be=0 is a no-op: no error, valid bit unchanged.
  - valid_cnt increments by 1 only when an invalid entry becomes valid.
- **Read (rd=1, wr=0):** the response appears on the next cycle.
  - dout_valid=1.
  - hit=valid[addr].
  - dout=mem[addr] when valid, otherwise 0.
  - Reads never change state.
- **Idle (wr=0, rd=0, clr=0):** no state change.

Other rules:
- valid_cnt never exceeds DEPTH and never underflows. It is the exact popcount of the valid bits at all times.
- Entries are only invalidated by clr or reset. There is no per-entry invalidate.

## Timing
- All outputs are registered. Reset value of dout, dout_valid, hit and error is 0; valid_cnt resets to 0.
- Reset also clears all memory and all valid bits.
- resetn is asserted asynchronously: outputs go to 0 immediately, without waiting for clk. Deassertion is synchronous to the design (synchronised upstream).
- Read latency is 1 cycle: a request sampled at edge N is presented after edge N and remains until edge N+1.
- dout, hit and error are single-cycle pulses. In any cycle with no read response, dout=0 and hit=0.
- error is registered with the same 1-cycle latency as the read response. error=1 never coincides with dout_valid=1.
- Write-then-read ordering:
  - A write at edge N followed by a read of the same address at edge N+1 returns the new data.
  - Back-to-back reads sustain one response per cycle.
- clr at edge N: a read at edge N+1 returns hit=0 and dout=0. valid_cnt=0 is visible after edge N.
- A reset asserted mid-operation discards any pending response. No dout_valid is produced after resetn rises until a new read is issued.

## Test plan
1. **Reset and invalid reads.** Use WIDTH=16, DEPTH=6. Reset, then read addresses 0 to 5.
   - Each read gives dout_valid=1, hit=0, dout=0x0000, error=0, valid_cnt=0.
2. **Full and partial writes.**
   - Write addr 2, din=0xBEEF, be=2'b11, then read addr 2: dout=0xBEEF, hit=1, valid_cnt=1.
   - Write addr 2, din=0x1234, be=2'b01, then read: dout=0xBE34.
   - Write addr 4, din=0xAB00, be=2'b10, then read: dout=0xAB00, valid_cnt=2.
3. **Illegal and out-of-range access.**
   - wr=1, rd=1, addr=2: error pulses one cycle, dout_valid=0, then a read of addr 2 still gives 0xBE34.
   - Write addr=6 or addr=7 with DEPTH=6: error=1, valid_cnt unchanged.
4. **be=0 write.** Write addr 0 with din=0xFFFF, be=0.
   - No error; a read of addr 0 gives hit=0, dout=0; valid_cnt unchanged.
5. **Fill, clear and overwrite.** Write all 6 entries: valid_cnt=6.
   - Rewrite addr 3: valid_cnt stays 6.
   - Pulse clr together with wr=1: valid_cnt=0, no error, and every subsequent read gives hit=0, dout=0.
6. **Reset mid-read and random stress.** Assert resetn low in the cycle after a read request.
   - Outputs drop to 0 asynchronously and there is no late dout_valid.
   - Then run 200 random cycles of addr, din, be, wr, rd and clr against a scoreboard model, checking every output each cycle.

Source files
------------

// File: rtl/ff_array_param.sv
// Parametrised flip-flop register array: per-entry valid bits, byte-enable writes, bulk clear, occupancy count.
// Read response and error strobe have 1-cycle latency; no backpressure, one request is accepted every cycle.
module ff_array_param #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int BW = WIDTH / 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din,
  input  logic [AW-1:0]    addr,
  input  logic             wr,
  input  logic             rd,
  input  logic [BW-1:0]    be,
  input  logic             clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             hit,
  output logic             error,
  output logic [CW-1:0]    valid_cnt
);

  localparam logic [AW:0] DEPTH_A = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic             in_range;
  logic [WIDTH-1:0] old_word;
  logic [WIDTH-1:0] new_word;

  assign in_range = ({1'b0, addr} < DEPTH_A);

  // Unselected bytes of a previously invalid entry read back as zero, never stale data.
  always_comb begin
    old_word = valid[addr] ? mem[addr] : '0;
    new_word = old_word;
    for (int i = 0; i < BW; i++) begin
      if (be[i]) new_word[8*i +: 8] = din[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      valid      <= '0;
      valid_cnt  <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      hit        <= 1'b0;
      error      <= 1'b0;
    end else begin
      dout       <= '0;
      dout_valid <= 1'b0;
      hit        <= 1'b0;
      error      <= 1'b0;
      if (clr) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        valid     <= '0;
        valid_cnt <= '0;
      end else if (wr && rd) begin
        error <= 1'b1;
      end else if ((wr || rd) && !in_range) begin
        error <= 1'b1;
      end else if (wr) begin
        if (|be) begin
          mem[addr]   <= new_word;
          valid[addr] <= 1'b1;
          if (!valid[addr]) valid_cnt <= valid_cnt + CW'(1);
        end
      end else if (rd) begin
        dout_valid <= 1'b1;
        hit        <= valid[addr];
        dout       <= valid[addr] ? mem[addr] : '0;
      end
    end
  end

endmodule

// File: tb/tb_ff_array_param.sv
// Scoreboard bench for ff_array_param (WIDTH=16, DEPTH=6): driver queues expected responses,
// a monitor 1 time unit after each rising edge pops and compares every output.
module tb_ff_array_param;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [15:0] din = '0;
  logic [2:0]  addr = '0;
  logic        wr = 1'b0, rd = 1'b0, clr = 1'b0;
  logic [1:0]  be = '0;
  logic [15:0] dout;
  logic        dout_valid, hit, error;
  logic [2:0]  valid_cnt;

  int n_vec = 0;
  int n_bad = 0;
  int seq   = 0;

  typedef struct {
    int          id;
    logic        dv, hit, err;
    logic [15:0] dout;
    logic [2:0]  cnt;
  } exp_t;
  exp_t q[$];

  // Random-phase reference state
  logic [15:0] m_mem [6];
  logic [5:0]  m_val;
  logic [2:0]  m_cnt;

  ff_array_param #(.WIDTH(16), .DEPTH(6)) dut (
    .clk(clk), .resetn(resetn), .din(din), .addr(addr), .wr(wr), .rd(rd),
    .be(be), .clr(clr), .dout(dout), .dout_valid(dout_valid), .hit(hit),
    .error(error), .valid_cnt(valid_cnt)
  );

  always #5 clk = ~clk;

  task automatic op(input logic w, r, c, input logic [2:0] a, input logic [15:0] d,
                    input logic [1:0] b, input logic edv, ehit, eerr,
                    input logic [15:0] edout, input logic [2:0] ecnt);
    exp_t e;
    @(negedge clk);
    wr = w; rd = r; clr = c; addr = a; din = d; be = b;
    e.id = seq; e.dv = edv; e.hit = ehit; e.err = eerr; e.dout = edout; e.cnt = ecnt;
    seq++;
    q.push_back(e);
  endtask

  task automatic wrv(input logic [2:0] a, input logic [15:0] d, input logic [1:0] b, input logic [2:0] ecnt);
    op(1'b1, 1'b0, 1'b0, a, d, b, 1'b0, 1'b0, 1'b0, 16'h0000, ecnt);
  endtask

  task automatic rdv(input logic [2:0] a, input logic ehit, input logic [15:0] edout, input logic [2:0] ecnt);
    op(1'b0, 1'b1, 1'b0, a, 16'h0000, 2'b00, 1'b1, ehit, 1'b0, edout, ecnt);
  endtask

  task automatic errv(input logic w, r, input logic [2:0] a, input logic [2:0] ecnt);
    op(w, r, 1'b0, a, 16'h5555, 2'b11, 1'b0, 1'b0, 1'b1, 16'h0000, ecnt);
  endtask

  task automatic idlev(input logic [2:0] ecnt);
    op(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, ecnt);
  endtask

  task automatic check_zero(input string nm);
    n_vec++;
    if (dout !== 16'h0 || dout_valid !== 1'b0 || hit !== 1'b0 || error !== 1'b0 || valid_cnt !== 3'd0) begin
      n_bad++;
      $display("FAIL %s: dv/hit/err/dout/cnt got %b/%b/%b/%h/%0d want all zero",
               nm, dout_valid, hit, error, dout, valid_cnt);
    end
  endtask

  // Monitor: one queued expectation per sampled edge; with nothing queued, no strobe may appear.
  always begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      if (dout_valid !== e.dv || hit !== e.hit || error !== e.err || dout !== e.dout || valid_cnt !== e.cnt) begin
        n_bad++;
        $display("FAIL vec%0d: dv/hit/err/dout/cnt got %b/%b/%b/%h/%0d want %b/%b/%b/%h/%0d",
                 e.id, dout_valid, hit, error, dout, valid_cnt, e.dv, e.hit, e.err, e.dout, e.cnt);
      end
    end else if (resetn) begin
      n_vec++;
      if (dout_valid !== 1'b0 || error !== 1'b0) begin
        n_bad++;
        $display("FAIL stray_strobe: dv/err got %b/%b want 0/0", dout_valid, error);
      end
    end
  end

  initial begin
    logic        w, r, c, edv, ehit, eerr;
    logic [2:0]  a;
    logic [15:0] d, edout, nw;
    logic [1:0]  b;

    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    resetn = 1'b1;

    // Invalid reads after reset
    for (int i = 0; i < 6; i++) rdv(3'(i), 1'b0, 16'h0000, 3'd0);

    // Full and partial writes, each followed immediately by a read
    wrv(3'd2, 16'hBEEF, 2'b11, 3'd1);
    rdv(3'd2, 1'b1, 16'hBEEF, 3'd1);
    wrv(3'd2, 16'h1234, 2'b01, 3'd1);
    rdv(3'd2, 1'b1, 16'hBE34, 3'd1);
    wrv(3'd4, 16'hAB00, 2'b10, 3'd2);
    rdv(3'd4, 1'b1, 16'hAB00, 3'd2);

    // Illegal and out-of-range accesses leave state untouched
    errv(1'b1, 1'b1, 3'd2, 3'd2);
    rdv(3'd2, 1'b1, 16'hBE34, 3'd2);
    errv(1'b1, 1'b0, 3'd6, 3'd2);
    errv(1'b1, 1'b0, 3'd7, 3'd2);
    errv(1'b0, 1'b1, 3'd6, 3'd2);
    idlev(3'd2);

    // be=0 write is a silent no-op
    wrv(3'd0, 16'hFFFF, 2'b00, 3'd2);
    rdv(3'd0, 1'b0, 16'h0000, 3'd2);

    // Fill, overwrite, then clear with wr and rd asserted alongside
    wrv(3'd0, 16'h0001, 2'b11, 3'd3);
    wrv(3'd1, 16'h0102, 2'b11, 3'd4);
    wrv(3'd3, 16'h0303, 2'b11, 3'd5);
    wrv(3'd5, 16'h0505, 2'b11, 3'd6);
    wrv(3'd3, 16'h00AA, 2'b01, 3'd6);
    rdv(3'd3, 1'b1, 16'h03AA, 3'd6);
    rdv(3'd1, 1'b1, 16'h0102, 3'd6);
    op(1'b1, 1'b0, 1'b1, 3'd1, 16'hFFFF, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0);
    for (int i = 0; i < 6; i++) rdv(3'(i), 1'b0, 16'h0000, 3'd0);
    op(1'b0, 1'b1, 1'b1, 3'd2, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0);

    // Reset asserted while a read response is on the outputs
    wrv(3'd2, 16'hCAFE, 2'b11, 3'd1);
    rdv(3'd2, 1'b1, 16'hCAFE, 3'd1);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    rd = 1'b0; wr = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    idlev(3'd0);
    idlev(3'd0);
    rdv(3'd2, 1'b0, 16'h0000, 3'd0);

    // Random stress against a reference model
    for (int i = 0; i < 6; i++) m_mem[i] = '0;
    m_val = '0;
    m_cnt = '0;
    for (int n = 0; n < 200; n++) begin
      c = ($urandom_range(0, 15) == 0);
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      a = 3'($urandom_range(0, 7));
      d = 16'($urandom);
      b = 2'($urandom_range(0, 3));
      edv = 1'b0; ehit = 1'b0; eerr = 1'b0; edout = '0;
      if (c) begin
        for (int i = 0; i < 6; i++) m_mem[i] = '0;
        m_val = '0;
        m_cnt = '0;
      end else if (w && r) begin
        eerr = 1'b1;
      end else if ((w || r) && a >= 3'd6) begin
        eerr = 1'b1;
      end else if (w) begin
        if (b != 2'b00) begin
          nw = m_val[a] ? m_mem[a] : 16'h0000;
          if (b[0]) nw[7:0]  = d[7:0];
          if (b[1]) nw[15:8] = d[15:8];
          m_mem[a] = nw;
          if (!m_val[a]) m_cnt = m_cnt + 3'd1;
          m_val[a] = 1'b1;
        end
      end else if (r) begin
        edv = 1'b1;
        ehit = m_val[a];
        edout = m_val[a] ? m_mem[a] : 16'h0000;
      end
      op(w, r, c, a, d, b, edv, ehit, eerr, edout, m_cnt);
    end
    idlev(m_cnt);

    repeat (4) @(posedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
